// File: rtl/dmac_desc_fifo_param.sv
// Parametrised DMA descriptor FIFO: queues {source, destination, size} triplets with registered
// outputs, almost-full/empty flags, synchronous flush and a registered ack/err status decode.
module dmac_desc_fifo_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic                      flush,
    input  logic [DATA_W-1:0]         in_sourceaddr,
    input  logic [DATA_W-1:0]         in_desaddr,
    input  logic [DATA_W-1:0]         in_datasize,
    output logic [DATA_W-1:0]         out_sourceaddr,
    output logic [DATA_W-1:0]         out_desaddr,
    output logic [DATA_W-1:0]         out_datasize,
    output logic                      out_valid,
    output logic [$clog2(DEPTH):0]    data_count,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      wr_ack,
    output logic                      wr_err,
    output logic                      rd_ack,
    output logic                      rd_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 3 * DATA_W;

    localparam logic [AW:0] DepthC  = DEPTH[AW:0];
    localparam logic [AW:0] AfullC  = AFULL_TH[AW:0];
    localparam logic [AW:0] AemptyC = AEMPTY_TH[AW:0];

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWrite  = 3'd1;
    localparam logic [2:0] StRead   = 3'd2;
    localparam logic [2:0] StWrRd   = 3'd3;
    localparam logic [2:0] StWrErr  = 3'd4;
    localparam logic [2:0] StRdErr  = 3'd5;
    localparam logic [2:0] StWrRerr = 3'd6;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [AW:0]   count_q, count_d;
    logic [2:0]    state_q, state_d;
    logic [EW-1:0] out_q;
    logic          out_valid_q;
    logic          push_ok, pop_ok;

    always_comb begin
        full         = (count_q == DepthC);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AfullC);
        almost_empty = (count_q <= AemptyC);
        pop_ok       = rd_en && !empty;
        push_ok      = wr_en && (!full || pop_ok);

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A rejected push can only happen at full with no pop, so the order below is exhaustive.
        if (push_ok && pop_ok)      state_d = StWrRd;
        else if (push_ok && rd_en)  state_d = StWrRerr;
        else if (push_ok)           state_d = StWrite;
        else if (pop_ok)            state_d = StRead;
        else if (wr_en)             state_d = StWrErr;
        else if (rd_en)             state_d = StRdErr;
        else                        state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push_ok) tail_q <= tail_q + 1'b1;
            if (pop_ok)  head_q <= head_q + 1'b1;
            count_q     <= count_d;
            state_q     <= state_d;
            out_q       <= pop_ok ? mem[head_q] : '0;
            out_valid_q <= pop_ok;
        end
    end

    // Storage is deliberately left unreset; outputs are zero-gated until a real pop.
    always_ff @(posedge clk) begin
        if (reset_n && !flush && push_ok) begin
            mem[tail_q] <= {in_sourceaddr, in_desaddr, in_datasize};
        end
    end

    always_comb begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        rd_ack = 1'b0;
        rd_err = 1'b0;
        case (state_q)
            StWrite:  wr_ack = 1'b1;
            StRead:   rd_ack = 1'b1;
            StWrRd:   begin wr_ack = 1'b1; rd_ack = 1'b1; end
            StWrErr:  wr_err = 1'b1;
            StRdErr:  rd_err = 1'b1;
            StWrRerr: begin wr_ack = 1'b1; rd_err = 1'b1; end
            default:  ;
        endcase
    end

    assign data_count     = count_q;
    assign out_valid      = out_valid_q;
    assign out_sourceaddr = out_q[EW-1:2*DATA_W];
    assign out_desaddr    = out_q[2*DATA_W-1:DATA_W];
    assign out_datasize   = out_q[DATA_W-1:0];

endmodule

// File: tb/tb_dmac_desc_fifo_param.sv
// Self-checking bench for dmac_desc_fifo_param (DEPTH=8, DATA_W=16): queue model plus
// scoreboard of popped descriptors, and a table of fill/drain vectors with fixed expectations.
module tb_dmac_desc_fifo_param;
    logic        clk = 1'b0;
    logic        reset_n, wr_en, rd_en, flush;
    logic [15:0] in_sourceaddr, in_desaddr, in_datasize;
    logic [15:0] out_sourceaddr, out_desaddr, out_datasize;
    logic        out_valid;
    logic [3:0]  data_count;
    logic        full, empty, almost_full, almost_empty;
    logic        wr_ack, wr_err, rd_ack, rd_err;

    always #5 clk = ~clk;

    dmac_desc_fifo_param #(.DATA_W(16), .DEPTH(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .flush         (flush),
        .in_sourceaddr (in_sourceaddr),
        .in_desaddr    (in_desaddr),
        .in_datasize   (in_datasize),
        .out_sourceaddr(out_sourceaddr),
        .out_desaddr   (out_desaddr),
        .out_datasize  (out_datasize),
        .out_valid     (out_valid),
        .data_count    (data_count),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .wr_ack        (wr_ack),
        .wr_err        (wr_err),
        .rd_ack        (rd_ack),
        .rd_err        (rd_err)
    );

    int checks = 0;
    int errors = 0;
    logic [47:0] mq[$];     // model of FIFO contents
    logic [47:0] exp_q[$];  // descriptors expected on out_* after the edge

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] src;
        logic [3:0]  cnt;
        logic        wa, we, ra, re;
        logic [15:0] osrc;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, then compare everything 1ns after the edge.
    task automatic step(input logic w, input logic r, input logic f, input logic rn,
                        input logic [47:0] dsc);
        int cnt;
        logic pop_ok, push_ok, e_wa, e_we, e_ra, e_re;
        logic [47:0] e;
        wr_en = w; rd_en = r; flush = f; reset_n = rn;
        {in_sourceaddr, in_desaddr, in_datasize} = dsc;
        cnt = mq.size();
        pop_ok = 1'b0; push_ok = 1'b0;
        e_wa = 1'b0; e_we = 1'b0; e_ra = 1'b0; e_re = 1'b0;
        if (!rn || f) begin
            mq.delete();
        end else begin
            pop_ok  = r && (cnt != 0);
            push_ok = w && ((cnt != 8) || pop_ok);
            e_wa = push_ok; e_we = w && !push_ok;
            e_ra = pop_ok;  e_re = r && !pop_ok;
            if (pop_ok)  exp_q.push_back(mq.pop_front());
            if (push_ok) mq.push_back(dsc);
        end
        @(posedge clk);
        #1;
        chk("count", 32'(data_count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == 8));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
        chk("ack_err", {28'h0, wr_ack, wr_err, rd_ack, rd_err}, {28'h0, e_wa, e_we, e_ra, e_re});
        chk("out_valid", 32'(out_valid), 32'(pop_ok));
        if (pop_ok && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_src", 32'(out_sourceaddr), 32'(e[47:32]));
            chk("out_des", 32'(out_desaddr), 32'(e[31:16]));
            chk("out_size", 32'(out_datasize), 32'(e[15:0]));
        end else begin
            chk("out_zero", {out_sourceaddr, out_desaddr}, 32'h0);
            chk("out_size_zero", 32'(out_datasize), 32'h0);
        end
    endtask

    function automatic logic [47:0] desc(input logic [15:0] i);
        return {16'h1000 + i, 16'h2000 + i, 16'h0010 + i};
    endfunction

    function automatic logic [47:0] rnd_desc();
        return {16'($urandom), 32'($urandom)};
    endfunction

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        in_sourceaddr = '0; in_desaddr = '0; in_datasize = '0;

        for (int i = 0; i < 9; i++) begin
            tbl[i] = '{1'b1, 1'b0, 16'(i), 4'(i < 8 ? i + 1 : 8),
                       i < 8, i >= 8, 1'b0, 1'b0, 16'h0};
            tbl[9 + i] = '{1'b0, 1'b1, 16'h0, 4'(i < 8 ? 7 - i : 0),
                           1'b0, 1'b0, i < 8, i >= 8, i < 8 ? 16'(16'h1000 + i) : 16'h0};
        end

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);

        // Fill to overflow, then drain to underflow
        for (int k = 0; k < 18; k++) begin
            step(tbl[k].wr, tbl[k].rd, 1'b0, 1'b1, desc(tbl[k].src));
            chk("tbl_count", 32'(data_count), 32'(tbl[k].cnt));
            chk("tbl_ack_err", {28'h0, wr_ack, wr_err, rd_ack, rd_err},
                {28'h0, tbl[k].wa, tbl[k].we, tbl[k].ra, tbl[k].re});
            chk("tbl_out_src", 32'(out_sourceaddr), 32'(tbl[k].osrc));
        end

        // Simultaneous push+pop at full, then at empty
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1, desc(16'(16'h40 + i)));
        step(1'b1, 1'b1, 1'b0, 1'b1, desc(16'h0055));
        chk("simul_full_count", 32'(data_count), 32'd8);
        chk("simul_full_oldest", 32'(out_sourceaddr), 32'h1040);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 1'b0, 1'b1, desc(16'h0066));
        chk("simul_empty", {24'h0, data_count, wr_ack, rd_err, rd_ack, out_valid}, 32'h1C);

        // Wrap with random data and random pop pairing
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, rnd_desc());
            step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, rnd_desc());
        end

        // Reset mid-traffic at count 5, with a push pending
        while (mq.size() < 5) step(1'b1, 1'b0, 1'b0, 1'b1, rnd_desc());
        while (mq.size() > 5) step(1'b0, 1'b1, 1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 1'b0, 1'b0, rnd_desc());
        chk("reset_count", 32'(data_count), 32'd0);

        // Flush at count 5 with a push pending, then one push
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, rnd_desc());
        step(1'b1, 1'b0, 1'b1, 1'b1, rnd_desc());
        chk("flush_count", 32'(data_count), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, desc(16'h0077));
        chk("post_flush_count", 32'(data_count), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
